// File: rtl/sad_frame_sequencer_if.sv
// Handshake/datapath bundle between sad_frame_sequencer, row and template memories and the PE array.
// match_count exists only when SAD_SEQ_MATCH_CNT_EN is defined.
interface sad_frame_sequencer_if #(
  parameter int IMG_W   = 640,
  parameter int TPL_W   = 40,
  parameter int ROW_AW  = 9,
  parameter int TPL_AW  = 6,
  parameter int COORD_W = 10
);
  logic               start;
  logic               busy;
  logic               done;
  logic               row_req;
  logic [ROW_AW-1:0]  row_addr;
  logic               row_ack;
  logic [IMG_W-1:0]   row_data;
  logic [TPL_AW-1:0]  tpl_addr;
  logic [TPL_W-1:0]   tpl_row;
  logic               pe_rst;
  logic [IMG_W-1:0]   pe_original;
  logic               pe_template;
  logic               pe_change_row;
  logic               pe_sad_status;
  logic [COORD_W-1:0] pe_coordinate;
  logic               match_valid;
  logic [ROW_AW-1:0]  match_row;
  logic [COORD_W-1:0] match_col;
`ifdef SAD_SEQ_MATCH_CNT_EN
  logic [ROW_AW:0]    match_count;
`endif

  modport master (
    input  start, row_ack, row_data, tpl_row, pe_sad_status, pe_coordinate,
    output busy, done, row_req, row_addr, tpl_addr, pe_rst, pe_original,
           pe_template, pe_change_row, match_valid, match_row, match_col
`ifdef SAD_SEQ_MATCH_CNT_EN
    , output match_count
`endif
  );

  modport slave (
    output start, row_ack, row_data, tpl_row, pe_sad_status, pe_coordinate,
    input  busy, done, row_req, row_addr, tpl_addr, pe_rst, pe_original,
           pe_template, pe_change_row, match_valid, match_row, match_col
`ifdef SAD_SEQ_MATCH_CNT_EN
    , input match_count
`endif
  );
endinterface

// File: rtl/sad_frame_sequencer.sv
// Frame sequencer for the vertical SAD PE array: per base row clear, fetch+stream TPL_H rows, settle, check.
// Stalls in FETCH until row_ack (1684 cycles/base at defaults); SAD_SEQ_MATCH_CNT_EN adds match_count.
module sad_frame_sequencer #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int TPL_W      = 40,
  parameter int TPL_H      = 40,
  parameter int ROW_AW     = 9,
  parameter int TPL_AW     = 6,
  parameter int COORD_W    = 10,
  parameter int SETTLE_CYC = 2
) (
  input logic clk,
  input logic rst,
  sad_frame_sequencer_if.master bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_SETTLE = 3'd5;
  localparam logic [2:0] S_CHECK  = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam int BIT_W = (TPL_W > 1) ? $clog2(TPL_W) : 1;
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic [2:0]         r_state;
  logic [ROW_AW-1:0]  r_base;
  logic [TPL_AW-1:0]  r_t;
  logic [BIT_W-1:0]   r_bit;
  logic [CNT_W-1:0]   r_cnt;
  logic [IMG_W-1:0]   r_orig;
  logic               r_match_valid;
  logic [ROW_AW-1:0]  r_match_row;
  logic [COORD_W-1:0] r_match_col;

  logic w_last_bit;
  logic w_last_t;
  logic w_last_base;
  logic w_settled;
  logic w_hit;

  assign w_last_bit  = (r_bit == BIT_W'(TPL_W - 1));
  assign w_last_t    = (r_t == TPL_AW'(TPL_H - 1));
  assign w_last_base = (r_base == ROW_AW'(IMG_H - TPL_H));
  assign w_settled   = (r_cnt == CNT_W'(SETTLE_CYC - 1));
  assign w_hit       = (r_state == S_CHECK) && bus.pe_sad_status;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_base        <= '0;
      r_t           <= '0;
      r_bit         <= '0;
      r_cnt         <= '0;
      r_orig        <= '0;
      r_match_valid <= 1'b0;
      r_match_row   <= '0;
      r_match_col   <= '0;
    end else begin
      r_match_valid <= 1'b0;
      case (r_state)
        S_IDLE:   if (bus.start) r_state <= S_CLEAR;
        S_CLEAR: begin
          r_t     <= '0;
          r_state <= S_FETCH;
        end
        S_FETCH: if (bus.row_ack) begin
          r_orig  <= bus.row_data;
          r_bit   <= '0;
          r_state <= S_STREAM;
        end
        S_STREAM: begin
          if (w_last_bit) r_state <= S_NEXT;
          else            r_bit   <= r_bit + BIT_W'(1);
        end
        S_NEXT: begin
          if (w_last_t) begin
            r_cnt   <= '0;
            r_state <= S_SETTLE;
          end else begin
            r_t     <= r_t + TPL_AW'(1);
            r_state <= S_FETCH;
          end
        end
        S_SETTLE: begin
          if (w_settled) r_state <= S_CHECK;
          else           r_cnt   <= r_cnt + CNT_W'(1);
        end
        S_CHECK: begin
          // match outputs are registered so row/col are valid alongside the pulse
          if (w_hit) begin
            r_match_valid <= 1'b1;
            r_match_row   <= r_base;
            r_match_col   <= bus.pe_coordinate;
          end
          if (w_last_base) begin
            r_state <= S_DONE;
          end else begin
            r_base  <= r_base + ROW_AW'(1);
            r_state <= S_CLEAR;
          end
        end
        S_DONE: begin
          r_base  <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SAD_SEQ_MATCH_CNT_EN
  logic [ROW_AW:0] r_match_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_match_cnt <= '0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_match_cnt <= '0;
    end else if (w_hit && (r_match_cnt != '1)) begin
      r_match_cnt <= r_match_cnt + (ROW_AW + 1)'(1);
    end
  end

  assign bus.match_count = r_match_cnt;
`endif

  assign bus.busy          = (r_state != S_IDLE);
  assign bus.done          = (r_state == S_DONE);
  assign bus.row_req       = (r_state == S_FETCH);
  assign bus.row_addr      = r_base + ROW_AW'(r_t);
  assign bus.tpl_addr      = r_t;
  assign bus.pe_rst        = (r_state == S_CLEAR);
  assign bus.pe_original   = r_orig;
  assign bus.pe_template   = (r_state == S_STREAM) ? bus.tpl_row[r_bit] : 1'b0;
  assign bus.pe_change_row = (r_state == S_NEXT);
  assign bus.match_valid   = r_match_valid;
  assign bus.match_row     = r_match_row;
  assign bus.match_col     = r_match_col;
endmodule

// File: tb/tb_sad_frame_sequencer.sv
// Directed + randomized frames for sad_frame_sequencer, checked against a per-frame expected trace.
`timescale 1ns/1ps
module tb_sad_frame_sequencer;
  localparam int IMG_W = 8, IMG_H = 4, TPL_W = 2, TPL_H = 2;
  localparam int ROW_AW = 3, TPL_AW = 2, COORD_W = 4, SETTLE_CYC = 2;
  localparam int NBASE    = IMG_H - TPL_H + 1;
  localparam int BASE_CYC = 1 + TPL_H * (TPL_W + 2) + SETTLE_CYC + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sad_frame_sequencer_if #(.IMG_W(IMG_W), .TPL_W(TPL_W), .ROW_AW(ROW_AW),
                           .TPL_AW(TPL_AW), .COORD_W(COORD_W)) bus ();

  sad_frame_sequencer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .TPL_W(TPL_W), .TPL_H(TPL_H),
                        .ROW_AW(ROW_AW), .TPL_AW(TPL_AW), .COORD_W(COORD_W),
                        .SETTLE_CYC(SETTLE_CYC)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;

  // stimulus tables, written only by the main initial block
  logic [IMG_W-1:0]   img [0:7];
  logic [TPL_W-1:0]   tpl [0:3];
  logic [NBASE-1:0]   match_mask;
  logic [COORD_W-1:0] coord_tab [0:NBASE-1];
  int                 delay_mode;   // 0 zero-wait, 1 five-cycle stall on first row-1 fetch, 2 random
  logic               mon_clr;
  logic [ROW_AW-1:0]  exp_mrow;
  logic [COORD_W-1:0] exp_mcol;

  // row memory responder
  int   req_age, rnd_delay, delay_sum, cur_delay;
  logic d1_used;

  always_comb begin
    cur_delay = 0;
    if (delay_mode == 1 && bus.row_addr == ROW_AW'(1) && !d1_used) cur_delay = 5;
    else if (delay_mode == 2) cur_delay = rnd_delay;
  end

  assign bus.row_ack  = bus.row_req && (req_age >= cur_delay);
  assign bus.row_data = img[bus.row_addr];
  assign bus.tpl_row  = tpl[bus.tpl_addr];

  always @(posedge clk) begin
    if (mon_clr || rst) begin
      req_age <= 0; rnd_delay <= 0; delay_sum <= 0; d1_used <= 1'b0;
    end else if (bus.row_req && bus.row_ack) begin
      req_age   <= 0;
      delay_sum <= delay_sum + cur_delay;
      if (delay_mode == 1 && bus.row_addr == ROW_AW'(1)) d1_used <= 1'b1;
      rnd_delay <= int'($urandom_range(0, 3));
    end else if (bus.row_req) begin
      req_age <= req_age + 1;
    end
  end

  // monitor: reconstructs the frame trace from the DUT outputs
  logic [ROW_AW-1:0]  obs_addr [$];
  logic [IMG_W-1:0]   obs_orig [$];
  logic               obs_bit  [$];
  logic [TPL_AW-1:0]  obs_taddr[$];
  logic [ROW_AW-1:0]  obs_mrow [$];
  logic [COORD_W-1:0] obs_mcol [$];
  int chg_cnt, clr_cnt, done_cnt, busy_cyc, pend_cyc, stray_tpl, stream_left, addr_moves;
  logic               prev_pend;
  logic [ROW_AW-1:0]  prev_addr;

  always @(negedge clk) begin
    if (mon_clr) begin
      obs_addr.delete(); obs_orig.delete(); obs_bit.delete(); obs_taddr.delete();
      obs_mrow.delete(); obs_mcol.delete();
      chg_cnt = 0; clr_cnt = 0; done_cnt = 0; busy_cyc = 0; pend_cyc = 0;
      stray_tpl = 0; stream_left = 0; addr_moves = 0; prev_pend = 1'b0; prev_addr = '0;
    end else if (rst) begin
      stream_left = 0; prev_pend = 1'b0;
    end else begin
      if (stream_left > 0) begin
        if (stream_left == TPL_W) obs_orig.push_back(bus.pe_original);
        obs_bit.push_back(bus.pe_template);
        obs_taddr.push_back(bus.tpl_addr);
        stream_left--;
      end else if (bus.pe_template !== 1'b0) begin
        stray_tpl++;
      end
      if (prev_pend && bus.row_addr !== prev_addr) addr_moves++;
      if (bus.row_req && !bus.row_ack) pend_cyc++;
      if (bus.row_req && bus.row_ack) begin
        obs_addr.push_back(bus.row_addr);
        stream_left = TPL_W;
      end
      prev_pend = bus.row_req && !bus.row_ack;
      prev_addr = bus.row_addr;
      if (bus.pe_change_row) chg_cnt++;
      if (bus.pe_rst) clr_cnt++;
      if (bus.done) done_cnt++;
      if (bus.busy && !bus.done) busy_cyc++;
      if (bus.match_valid) begin
        obs_mrow.push_back(bus.match_row);
        obs_mcol.push_back(bus.match_col);
      end
    end
  end

  // array status model: base b is fully accumulated once (b+1)*TPL_H change_row pulses were seen
  assign bus.pe_sad_status = (chg_cnt > 0 && chg_cnt % TPL_H == 0) ?
                             match_mask[(chg_cnt / TPL_H - 1) % NBASE] : 1'b0;
  assign bus.pe_coordinate = (chg_cnt > 0) ? coord_tab[(chg_cnt / TPL_H + NBASE - 1) % NBASE] : '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tg, input logic [ROW_AW-1:0] mrow, input logic [COORD_W-1:0] mcol);
    chk({tg, " busy"}, bus.busy, 0);
    chk({tg, " done"}, bus.done, 0);
    chk({tg, " row_req"}, bus.row_req, 0);
    chk({tg, " row_addr"}, bus.row_addr, 0);
    chk({tg, " tpl_addr"}, bus.tpl_addr, 0);
    chk({tg, " pe_rst"}, bus.pe_rst, 0);
    chk({tg, " pe_original"}, bus.pe_original, 0);
    chk({tg, " pe_template"}, bus.pe_template, 0);
    chk({tg, " pe_change_row"}, bus.pe_change_row, 0);
    chk({tg, " match_valid"}, bus.match_valid, 0);
    chk({tg, " match_row"}, bus.match_row, mrow);
    chk({tg, " match_col"}, bus.match_col, mcol);
`ifdef SAD_SEQ_MATCH_CNT_EN
    chk({tg, " match_count"}, bus.match_count, 0);
`endif
  endtask

  task automatic randomize_tables(input bit with_matches);
    for (int i = 0; i < 8; i++) img[i] = IMG_W'($urandom);
    for (int i = 0; i < 4; i++) tpl[i] = TPL_W'($urandom);
    for (int i = 0; i < NBASE; i++) coord_tab[i] = COORD_W'($urandom);
    match_mask = with_matches ? NBASE'($urandom) : '0;
  endtask

  task automatic start_frame();
    mon_clr = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    mon_clr  = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tg);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_cnt > 0) begin ok = 1'b1; break; end
    end
    chk({tg, " done within bound"}, ok, 1);
    repeat (3) @(negedge clk);
  endtask

  // expected frame: bases 0..IMG_H-TPL_H, each reading rows base..base+TPL_H-1 and streaming every template row LSB first
  task automatic check_frame(input string tg, input int exp_stall);
    logic [ROW_AW-1:0]  ea [$];
    logic [IMG_W-1:0]   eo [$];
    logic               eb [$];
    logic [TPL_AW-1:0]  et [$];
    logic [ROW_AW-1:0]  emr[$];
    logic [COORD_W-1:0] emc[$];
    for (int b = 0; b < NBASE; b++) begin
      for (int t = 0; t < TPL_H; t++) begin
        ea.push_back(ROW_AW'(b + t));
        eo.push_back(img[b + t]);
        for (int k = 0; k < TPL_W; k++) begin
          eb.push_back(tpl[t][k]);
          et.push_back(TPL_AW'(t));
        end
      end
      if (match_mask[b]) begin
        emr.push_back(ROW_AW'(b));
        emc.push_back(coord_tab[b]);
      end
    end
    chk({tg, " done pulses"}, done_cnt, 1);
    chk({tg, " busy cycles"}, busy_cyc, NBASE * BASE_CYC + exp_stall);
    chk({tg, " stall cycles"}, pend_cyc, exp_stall);
    chk({tg, " addr moved while pending"}, addr_moves, 0);
    chk({tg, " change_row pulses"}, chg_cnt, NBASE * TPL_H);
    chk({tg, " pe_rst pulses"}, clr_cnt, NBASE);
    chk({tg, " template outside stream"}, stray_tpl, 0);
    chk({tg, " fetch count"}, obs_addr.size(), ea.size());
    chk({tg, " stream bit count"}, obs_bit.size(), eb.size());
    for (int i = 0; i < ea.size(); i++) begin
      chk($sformatf("%s row_addr[%0d]", tg, i), (i < obs_addr.size()) ? obs_addr[i] : 'x, ea[i]);
      chk($sformatf("%s pe_original[%0d]", tg, i), (i < obs_orig.size()) ? obs_orig[i] : 'x, eo[i]);
    end
    for (int i = 0; i < eb.size(); i++) begin
      chk($sformatf("%s pe_template[%0d]", tg, i), (i < obs_bit.size()) ? obs_bit[i] : 1'bx, eb[i]);
      chk($sformatf("%s tpl_addr[%0d]", tg, i), (i < obs_taddr.size()) ? obs_taddr[i] : 'x, et[i]);
    end
    chk({tg, " match pulses"}, obs_mrow.size(), emr.size());
    for (int i = 0; i < emr.size(); i++) begin
      chk($sformatf("%s match_row[%0d]", tg, i), (i < obs_mrow.size()) ? obs_mrow[i] : 'x, emr[i]);
      chk($sformatf("%s match_col[%0d]", tg, i), (i < obs_mcol.size()) ? obs_mcol[i] : 'x, emc[i]);
    end
    if (emr.size() > 0) begin
      exp_mrow = emr[emr.size() - 1];
      exp_mcol = emc[emc.size() - 1];
    end
    chk({tg, " match_row held"}, bus.match_row, exp_mrow);
    chk({tg, " match_col held"}, bus.match_col, exp_mcol);
    chk({tg, " idle after done"}, bus.busy, 0);
`ifdef SAD_SEQ_MATCH_CNT_EN
    chk({tg, " match_count"}, bus.match_count, emr.size());
`endif
  endtask

  initial begin
    bus.start  = 1'b0;
    delay_mode = 0;
    mon_clr    = 1'b1;
    exp_mrow   = '0;
    exp_mcol   = '0;
    randomize_tables(1'b0);
    repeat (3) @(negedge clk);
    chk_quiet("reset", '0, '0);
    rst = 1'b0;
    mon_clr = 1'b0;
    repeat (2) @(negedge clk);

    // zero-wait, no matches
    start_frame();
    wait_done("zero_wait");
    check_frame("zero_wait", 0);
    chk("zero_wait frame length", busy_cyc, 36);

    // five-cycle stall on the first fetch of row 1
    randomize_tables(1'b0);
    delay_mode = 1;
    start_frame();
    wait_done("stall_row1");
    check_frame("stall_row1", 5);
    delay_mode = 0;

    // template 2'b10 on both rows, match at base 1 column 5
    randomize_tables(1'b0);
    tpl[0] = 2'b10;
    tpl[1] = 2'b10;
    match_mask   = 3'b010;
    coord_tab[1] = 4'd5;
    start_frame();
    wait_done("match_b1");
    check_frame("match_b1", 0);
    chk("match_b1 row", bus.match_row, 1);
    chk("match_b1 col", bus.match_col, 5);

    // reset during STREAM of base 1
    randomize_tables(1'b1);
    start_frame();
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (obs_addr.size() == 3) begin seen = 1'b1; break; end
      end
      chk("abort reached base1 fetch", seen, 1);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_mrow = '0;
    exp_mcol = '0;
    chk_quiet("abort", '0, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort no done", done_cnt, 0);
    chk("abort stays idle", bus.busy, 0);

    // restart after abort with random stalls and matches
    delay_mode = 2;
    start_frame();
    wait_done("restart");
    check_frame("restart", delay_sum);
    delay_mode = 0;

    // start pulses while busy are ignored
    randomize_tables(1'b1);
    start_frame();
    repeat (8) @(negedge clk);
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    repeat (13) @(negedge clk);
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    wait_done("start_busy");
    check_frame("start_busy", 0);
    repeat (20) @(negedge clk);
    chk("start_busy single done", done_cnt, 1);
    chk("start_busy no restart", bus.busy, 0);

    // random frames
    for (int f = 0; f < 4; f++) begin
      randomize_tables(1'b1);
      delay_mode = 2;
      start_frame();
      wait_done($sformatf("rand%0d", f));
      check_frame($sformatf("rand%0d", f), delay_sum);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
